// File: rtl/id_ex_pipe_stage_if.sv
// ID/EX stage handshake and payload bundle; the slave modport is the stage's own view.
interface id_ex_pipe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned ADDR_W = 5
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [OP_W-1:0]   ALUop_i;
  logic [DATA_W-1:0] oprand1_i;
  logic [DATA_W-1:0] oprand2_i;
  logic [ADDR_W-1:0] writeAddr_i;
  logic              writeEnable_i;
  logic              valid_o;
  logic              ready_i;
  logic [OP_W-1:0]   ALUop_o;
  logic [DATA_W-1:0] oprand1_o;
  logic [DATA_W-1:0] oprand2_o;
  logic [ADDR_W-1:0] writeAddr_o;
  logic              writeEnable_o;

  modport master (
    output flush_i, valid_i, ALUop_i, oprand1_i, oprand2_i, writeAddr_i, writeEnable_i, ready_i,
    input  ready_o, valid_o, ALUop_o, oprand1_o, oprand2_o, writeAddr_o, writeEnable_o
  );

  modport slave (
    input  flush_i, valid_i, ALUop_i, oprand1_i, oprand2_i, writeAddr_i, writeEnable_i, ready_i,
    output ready_o, valid_o, ALUop_o, oprand1_o, oprand2_o, writeAddr_o, writeEnable_o
  );
endinterface

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake and synchronous flush.
// Define PIPE_SKID_EN for a registered ready_o backed by a one-entry skid register.
module id_ex_pipe_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NOP_OP = 0
) (
  input logic               clk,
  input logic               rst,
  id_ex_pipe_stage_if.slave bus
);
  localparam logic [OP_W-1:0] NopOp = OP_W'(NOP_OP);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] wa;
    logic              we;
  } beat_t;

  localparam beat_t IdleBeat = '{op: NopOp, a: '0, b: '0, wa: '0, we: 1'b0};

  beat_t in_beat;
  beat_t out_q, out_d;
  logic  ready;
  logic  accept;
  logic  retire;

  // Writes to register zero are architecturally discarded, so drop them here.
  assign in_beat = '{op: bus.ALUop_i, a: bus.oprand1_i, b: bus.oprand2_i, wa: bus.writeAddr_i,
                     we: bus.writeEnable_i && (bus.writeAddr_i != '0)};

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;
  beat_t  skid_q, skid_d;
  logic   ready_q;

  assign ready  = ready_q;
  assign accept = bus.valid_i && ready;
  assign retire = (state_q != StEmpty) && bus.ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          out_d   = in_beat;
        end
      end
      StOne: begin
        if (accept && !retire) begin
          state_d = StFull;
          skid_d  = in_beat;
        end else if (accept) begin
          out_d = in_beat;
        end else if (retire) begin
          state_d = StEmpty;
          out_d   = IdleBeat;
        end
      end
      StFull: begin
        if (retire) begin
          state_d = StOne;
          out_d   = skid_q;
        end
      end
      default: begin
        state_d = StEmpty;
        out_d   = IdleBeat;
      end
    endcase
    // Flush wins over everything, including a beat offered this cycle.
    if (bus.flush_i) begin
      state_d = StEmpty;
      out_d   = IdleBeat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      out_q   <= IdleBeat;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != StFull);
    end
  end
`else
  typedef enum logic {StEmpty, StOne} state_e;

  state_e state_q, state_d;

  // Without a skid entry, a full stage may only accept while it also retires.
  assign ready  = (state_q == StEmpty) || bus.ready_i;
  assign accept = bus.valid_i && ready;
  assign retire = (state_q != StEmpty) && bus.ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (accept) begin
      state_d = StOne;
      out_d   = in_beat;
    end else if (retire) begin
      state_d = StEmpty;
      out_d   = IdleBeat;
    end
    if (bus.flush_i) begin
      state_d = StEmpty;
      out_d   = IdleBeat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      out_q   <= IdleBeat;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end
`endif

  assign bus.ready_o       = ready;
  assign bus.valid_o       = (state_q != StEmpty);
  assign bus.ALUop_o       = out_q.op;
  assign bus.oprand1_o     = out_q.a;
  assign bus.oprand2_o     = out_q.b;
  assign bus.writeAddr_o   = out_q.wa;
  assign bus.writeEnable_o = out_q.we;
endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage: directed scenarios plus random traffic
// checked against a queue-based model of the stage.
module tb_id_ex_pipe_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] wa;
    logic              we;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  id_ex_pipe_stage_if #(.DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W)) bus ();

  id_ex_pipe_stage #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W),
    .ADDR_W(ADDR_W),
    .NOP_OP(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Occupancy-based model: skid mode holds up to two beats, otherwise one.
  function automatic bit model_ready();
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || (bus.ready_i == 1'b1);
`endif
  endfunction

  task automatic check_model();
    chk("valid_o", 64'(bus.valid_o), 64'(q.size() != 0));
    chk("ready_o", 64'(bus.ready_o), 64'(model_ready()));
    if (q.size() != 0) begin
      chk("ALUop_o", 64'(bus.ALUop_o), 64'(q[0].op));
      chk("oprand1_o", 64'(bus.oprand1_o), 64'(q[0].a));
      chk("oprand2_o", 64'(bus.oprand2_o), 64'(q[0].b));
      chk("writeAddr_o", 64'(bus.writeAddr_o), 64'(q[0].wa));
      chk("writeEnable_o", 64'(bus.writeEnable_o), 64'(q[0].we));
    end else begin
      chk("idle_ALUop_o", 64'(bus.ALUop_o), 64'd0);
      chk("idle_writeEnable_o", 64'(bus.writeEnable_o), 64'd0);
    end
  endtask

  task automatic drive(input bit v, input bit r, input bit f, input logic [OP_W-1:0] op,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [ADDR_W-1:0] wa, input bit we);
    bus.valid_i       = v;
    bus.ready_i       = r;
    bus.flush_i       = f;
    bus.ALUop_i       = op;
    bus.oprand1_i     = a;
    bus.oprand2_i     = b;
    bus.writeAddr_i   = wa;
    bus.writeEnable_i = we;
    #1;
    check_model();
  endtask

  task automatic tick();
    bit    acc;
    bit    ret;
    beat_t nb;
    acc = (bus.valid_i == 1'b1) && model_ready();
    ret = (q.size() != 0) && (bus.ready_i == 1'b1);
    nb  = '{op: bus.ALUop_i, a: bus.oprand1_i, b: bus.oprand2_i, wa: bus.writeAddr_i,
            we: (bus.writeEnable_i == 1'b1) && (bus.writeAddr_i != '0)};
    @(posedge clk);
    if (bus.flush_i == 1'b1) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(nb);
    end
    @(negedge clk);
  endtask

  initial begin
    rst               = 1'b1;
    bus.valid_i       = 1'b0;
    bus.ready_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.ALUop_i       = '0;
    bus.oprand1_i     = '0;
    bus.oprand2_i     = '0;
    bus.writeAddr_i   = '0;
    bus.writeEnable_i = 1'b0;
    #2;
    chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("rst_ready_o", 64'(bus.ready_o), 64'd1);
    chk("rst_ALUop_o", 64'(bus.ALUop_o), 64'd0);
    chk("rst_oprand1_o", 64'(bus.oprand1_o), 64'd0);
    chk("rst_oprand2_o", 64'(bus.oprand2_o), 64'd0);
    chk("rst_writeAddr_o", 64'(bus.writeAddr_o), 64'd0);
    chk("rst_writeEnable_o", 64'(bus.writeEnable_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate: output i appears at step i.
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 1'b1, 1'b0, OP_W'(i + 3), DATA_W'(i + 1), DATA_W'($urandom),
            ADDR_W'(i + 1), 1'b1);
      if (i >= 1 && i <= 8) chk("stream_oprand1", 64'(bus.oprand1_o), 64'(i));
      tick();
    end

    // Back-pressure during beats 1 and 2.
    drive(1'b1, 1'b0, 1'b0, 5'd7, 32'd1, 32'hA1, 5'd3, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd8, 32'd2, 32'hA2, 5'd4, 1'b1);
`ifdef PIPE_SKID_EN
    chk("bp_ready_one", 64'(bus.ready_o), 64'd1);
`else
    chk("bp_ready_stall", 64'(bus.ready_o), 64'd0);
`endif
    chk("bp_hold1", 64'(bus.oprand1_o), 64'd1);
    tick();
`ifdef PIPE_SKID_EN
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("bp_ready_full", 64'(bus.ready_o), 64'd0);
`else
    drive(1'b1, 1'b1, 1'b0, 5'd8, 32'd2, 32'hA2, 5'd4, 1'b1);
    chk("bp_ready_free", 64'(bus.ready_o), 64'd1);
`endif
    chk("bp_first", 64'(bus.oprand1_o), 64'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("bp_second", 64'(bus.oprand1_o), 64'd2);
    chk("bp_ready_back", 64'(bus.ready_o), 64'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();

    // Write to register zero loses its enable.
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h55, 32'h66, 5'd0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("rz_valid", 64'(bus.valid_o), 64'd1);
    chk("rz_we", 64'(bus.writeEnable_o), 64'd0);
    tick();

    // Flush with the stage loaded and a beat on offer.
    drive(1'b1, 1'b0, 1'b0, 5'd9, 32'd10, 32'd0, 5'd1, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd10, 32'd11, 32'd0, 5'd2, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd11, 32'd12, 32'd0, 5'd3, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("flush_valid", 64'(bus.valid_o), 64'd0);
    chk("flush_ALUop", 64'(bus.ALUop_o), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      tick();
    end

    // Asynchronous reset between edges with a beat held.
    drive(1'b1, 1'b0, 1'b0, 5'd9, 32'd20, 32'd21, 5'd5, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("arst_ready_o", 64'(bus.ready_o), 64'd1);
    chk("arst_ALUop_o", 64'(bus.ALUop_o), 64'd0);
    chk("arst_oprand1_o", 64'(bus.oprand1_o), 64'd0);
    chk("arst_oprand2_o", 64'(bus.oprand2_o), 64'd0);
    chk("arst_writeAddr_o", 64'(bus.writeAddr_o), 64'd0);
    chk("arst_writeEnable_o", 64'(bus.writeEnable_o), 64'd0);
    q.delete();
    #1 rst = 1'b0;
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'd30, 32'd31, 5'd6, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("post_rst_accept", 64'(bus.oprand1_o), 64'd30);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            OP_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
            ($urandom_range(0, 3) == 0) ? ADDR_W'(0) : ADDR_W'($urandom),
            $urandom_range(0, 1) == 1);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
